// File: rtl/max3421_pkg.sv
// rtl/max3421_pkg.sv - shared types and command-field positions for the MAX3421 SPI responder
package max3421_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam int REG_COUNT    = 32;
  localparam int ADDR_W       = $clog2(REG_COUNT);
  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_DIR_BIT  = 1;
endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - multi-stage synchronizer with rise/fall detect for asynchronous SPI pins
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out,
  output logic rise_out,
  output logic fall_out
);
  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_in};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign q_out    = chain_q[SYNC_STAGES-1];
  assign rise_out = q_out & ~prev_q;
  assign fall_out = ~q_out & prev_q;
endmodule

// File: rtl/max3421_spi_responder.sv
// rtl/max3421_spi_responder.sv - MAX3421-style SPI target with 32x8 register file
// MAX3421_SPI_RESP_AUTOINC_EN: advance the register address after each data byte.
module max3421_spi_responder
  import max3421_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sclk_in,
  input  logic              mosi_in,
  input  logic              n_ss_in,
  input  logic [7:0]        status_in,
  output logic              miso_out,
  output logic              miso_oe_out,
  output logic              wr_valid_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  input  logic [ADDR_W-1:0] host_addr_in,
  output logic [7:0]        host_data_out,
  output logic              txn_done_out,
  output logic [6:0]        byte_count_out
);
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic sclk_lvl_unused, ss_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(sclk_in),
    .q_out(sclk_lvl_unused), .rise_out(sclk_rise), .fall_out(sclk_fall));

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(n_ss_in),
    .q_out(ss_lvl_unused), .rise_out(ss_rise), .fall_out(ss_fall));

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk_in(clk_in), .rst_in(rst_in), .d_in(mosi_in),
    .q_out(mosi_s), .rise_out(mosi_rise_unused), .fall_out(mosi_fall_unused));

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        rx_q;
  logic [7:0]        tx_q;
  logic [ADDR_W-1:0] addr_q, next_addr;
  logic              wr_q;
  logic [7:0]        regs [REG_COUNT];
  logic [7:0]        rx_byte, tx_load;
  logic              byte_done, wr_en;

  assign rx_byte     = {rx_q, mosi_s};
  assign miso_out    = tx_q[7];
  assign miso_oe_out = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    wr_en     = 1'b0;
    next_addr = addr_q;
    tx_load   = '0;
    case (state_q)
      IDLE: if (ss_fall) state_d = CMD;
      CMD, DATA: begin
        // nSS rise takes priority over a coincident SCLK edge
        if (ss_rise) begin
          state_d = IDLE;
        end else if (sclk_rise && bit_cnt_q == 3'd7) begin
          byte_done = 1'b1;
          state_d   = DATA;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == CMD) begin
      tx_load = regs[rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]];
    end else begin
      wr_en = byte_done && wr_q;
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
      next_addr = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`else
      next_addr = addr_q;
`endif
      // write-first bypass so a frozen address returns the byte just written
      tx_load = (wr_en && next_addr == addr_q) ? rx_byte : regs[next_addr];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_q           <= '0;
      tx_q           <= '0;
      addr_q         <= '0;
      wr_q           <= 1'b0;
      wr_valid_out   <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      host_data_out  <= '0;
      txn_done_out   <= 1'b0;
      byte_count_out <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      state_q       <= state_d;
      wr_valid_out  <= wr_en;
      txn_done_out  <= ss_rise;
      host_data_out <= regs[host_addr_in];
      if (wr_en) begin
        regs[addr_q] <= rx_byte;
        wr_addr_out  <= addr_q;
        wr_data_out  <= rx_byte;
      end

      if (state_q == IDLE) begin
        if (ss_fall) begin
          tx_q           <= status_in;
          bit_cnt_q      <= '0;
          byte_count_out <= '0;
        end
      end else if (!ss_rise) begin
        if (sclk_rise) begin
          rx_q      <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (byte_done) begin
            tx_q <= tx_load;
            if (byte_count_out != 7'd127) byte_count_out <= byte_count_out + 7'd1;
            if (state_q == CMD) begin
              addr_q <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
              wr_q   <= rx_byte[CMD_DIR_BIT];
            end else begin
              addr_q <= next_addr;
            end
          end
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
          // the fall after a byte's 8th rise keeps the freshly loaded bit 7
          tx_q <= {tx_q[6:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_max3421_spi_responder.sv
// tb/tb_max3421_spi_responder.sv - scoreboard bench for the MAX3421 SPI responder
module tb_max3421_spi_responder;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n, sclk, mosi, n_ss;
  logic [7:0] status;
  logic [4:0] host_addr;
  logic       miso, miso_oe, wr_valid, txn_done;
  logic [4:0] wr_addr;
  logic [7:0] wr_data, host_data;
  logic [6:0] byte_count;

  int tests = 0;
  int fails = 0;
  int txn_done_cnt = 0;
  int miso_bits = 0;
  int done_before;
  logic [7:0]  miso_shift = '0;
  logic [7:0]  miso_exp[$];
  logic [12:0] wr_exp[$];

  always #5 clk = ~clk;

  max3421_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk_in(clk), .rst_in(rst_n), .sclk_in(sclk), .mosi_in(mosi), .n_ss_in(n_ss),
    .status_in(status), .miso_out(miso), .miso_oe_out(miso_oe),
    .wr_valid_out(wr_valid), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .host_addr_in(host_addr), .host_data_out(host_data),
    .txn_done_out(txn_done), .byte_count_out(byte_count));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_txn(input logic [7:0] st);
    status = st;
    n_ss   = 1'b0;
    tick(1);
  endtask

  task automatic end_txn();
    tick(HALF);
    n_ss = 1'b1;
    tick(HALF);
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic check_reg(input logic [4:0] a, input logic [7:0] exp, input string nm);
    host_addr = a;
    tick(2);
    check(nm, 32'(host_data), 32'(exp));
  endtask

  // MISO monitor: host-side capture on SCLK rise, partial bytes dropped on nSS rise
  initial forever begin
    @(posedge sclk or posedge n_ss);
    if (n_ss === 1'b1) begin
      miso_bits = 0;
    end else begin
      miso_shift = {miso_shift[6:0], miso};
      miso_bits++;
      if (miso_bits == 8) begin
        miso_bits = 0;
        if (miso_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL miso_unexpected: got 0x%0h, expected no byte", miso_shift);
        end else begin
          check("miso_byte", 32'(miso_shift), 32'(miso_exp.pop_front()));
        end
      end
    end
  end

  // write / txn_done monitor
  initial forever begin
    @(negedge clk);
    if (txn_done === 1'b1) txn_done_cnt++;
    if (wr_valid === 1'b1) begin
      if (wr_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got addr %0d data 0x%0h, expected none", wr_addr, wr_data);
      end else begin
        check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(wr_exp.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; n_ss = 1'b1; status = '0; host_addr = '0;
    tick(4);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_host_data", 32'(host_data), 32'd0);
    check("rst_txn_done", 32'(txn_done), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // preload reg5 = 0xA5
    begin_txn(8'h00);
    miso_exp.push_back(8'h00); miso_exp.push_back(8'h00);
    wr_exp.push_back({5'd5, 8'hA5});
    spi_byte(8'h2A, 8); spi_byte(8'hA5, 8);
    end_txn();
    check_reg(5'd5, 8'hA5, "preload_reg5");

    // read reg5 with status 0x3C
    done_before = txn_done_cnt;
    begin_txn(8'h3C);
    miso_exp.push_back(8'h3C); miso_exp.push_back(8'hA5);
    spi_byte(8'h28, 8); spi_byte(8'h00, 8);
    end_txn();
    check("read_byte_count", 32'(byte_count), 32'd2);
    check("read_txn_done", 32'(txn_done_cnt - done_before), 32'd1);

    // write burst to addr 10
    begin_txn(8'h81);
    miso_exp.push_back(8'h81); miso_exp.push_back(8'h00);
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
    miso_exp.push_back(8'h00);
    wr_exp.push_back({5'd10, 8'h11}); wr_exp.push_back({5'd11, 8'h22});
`else
    miso_exp.push_back(8'h11);
    wr_exp.push_back({5'd10, 8'h11}); wr_exp.push_back({5'd10, 8'h22});
`endif
    spi_byte(8'h52, 8); spi_byte(8'h11, 8); spi_byte(8'h22, 8);
    end_txn();
    check("burst_byte_count", 32'(byte_count), 32'd3);
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
    check_reg(5'd11, 8'h22, "burst_reg11");
    check_reg(5'd10, 8'h11, "burst_reg10");
`else
    check_reg(5'd10, 8'h22, "burst_reg10");
    check_reg(5'd11, 8'h00, "burst_reg11");
`endif

    // address wrap from 31
    begin_txn(8'h5A);
    miso_exp.push_back(8'h5A); miso_exp.push_back(8'h00);
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
    miso_exp.push_back(8'h00);
    wr_exp.push_back({5'd31, 8'h01}); wr_exp.push_back({5'd0, 8'h02});
`else
    miso_exp.push_back(8'h01);
    wr_exp.push_back({5'd31, 8'h01}); wr_exp.push_back({5'd31, 8'h02});
`endif
    spi_byte(8'hFA, 8); spi_byte(8'h01, 8); spi_byte(8'h02, 8);
    end_txn();
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
    check_reg(5'd31, 8'h01, "wrap_reg31");
    check_reg(5'd0, 8'h02, "wrap_reg0");
`else
    check_reg(5'd31, 8'h02, "wrap_reg31");
    check_reg(5'd0, 8'h00, "wrap_reg0");
`endif

    // abort mid-byte after one data byte
    done_before = txn_done_cnt;
    begin_txn(8'h96);
    miso_exp.push_back(8'h96);
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
    miso_exp.push_back(8'h11);
`else
    miso_exp.push_back(8'h22);
`endif
    wr_exp.push_back({5'd10, 8'h5A});
    spi_byte(8'h52, 8); spi_byte(8'h5A, 8); spi_byte(8'hF0, 4);
    end_txn();
    check("abort_byte_count", 32'(byte_count), 32'd2);
    check("abort_txn_done", 32'(txn_done_cnt - done_before), 32'd1);
    check_reg(5'd10, 8'h5A, "abort_reg10");
`ifdef MAX3421_SPI_RESP_AUTOINC_EN
    check_reg(5'd11, 8'h22, "abort_reg11");
`else
    check_reg(5'd11, 8'h00, "abort_reg11");
`endif

    // reset in the middle of a byte
    begin_txn(8'h44);
    miso_exp.push_back(8'h44);
    spi_byte(8'h52, 8); spi_byte(8'hAA, 3);
    rst_n = 1'b0; n_ss = 1'b1; sclk = 1'b0;
    tick(1);
    check("midrst_miso_oe", 32'(miso_oe), 32'd0);
    check("midrst_byte_count", 32'(byte_count), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check_reg(5'd10, 8'h00, "midrst_reg10");
    check_reg(5'd31, 8'h00, "midrst_reg31");

    // read back reg10 after reset through SPI
    begin_txn(8'hC3);
    miso_exp.push_back(8'hC3); miso_exp.push_back(8'h00);
    spi_byte(8'h50, 8); spi_byte(8'h00, 8);
    end_txn();
    check("post_rst_byte_count", 32'(byte_count), 32'd2);

    tick(4);
    check("miso_queue_drained", 32'(miso_exp.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_exp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/max3421_spi_responder.md
# max3421_spi_responder

SPI target-side counterpart to the MAX3421 SPI host engine, modelling the MAX3421 command/register protocol. It oversamples the host's SCLK/MOSI/nSS on the system clock and decodes the command byte. It serves a 32×8 register file with full-duplex status/old-data return on MISO. It serves both as the simulation/loopback peer for the host engine and as a target port when this FPGA is exposed to an external SPI host.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk_in`, `mosi_in`, `n_ss_in` (≥2).

Ports:
- `clk_in`  input  1  system clock; must be ≥8× SCLK frequency.
- `rst_in`  input  1  reset, synchronous, active-low.
- `sclk_in`  input  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0), asynchronous.
- `mosi_in`  input  1  host data, MSB first.
- `n_ss_in`  input  1  active-low select.
- `status_in`  input  8  status byte returned during the command byte; latched at nSS fall.
- `miso_out`  output  1  target data, MSB first.
- `miso_oe_out`  output  1  tristate enable; 1 while selected.
- `wr_valid_out`  output  1  one-cycle pulse per committed write byte.
- `wr_addr_out`  output  5  register address of the write.
- `wr_data_out`  output  8  written data.
- `host_addr_in`  input  5  local read port address.
- `host_data_out`  output  8  `reg[host_addr_in]`, registered with 1-cycle latency.
- `txn_done_out`  output  1  one-cycle pulse on nSS rise.
- `byte_count_out`  output  7  completed bytes in last/current transaction (saturates at 127).

## Operation
- Command byte: bits[7:3] = register address, bit1 = 1 write / 0 read, bits 2 and 0 ignored.
- States: IDLE → CMD on nSS fall; CMD → DATA after 8th SCLK rise; CMD/DATA → IDLE on nSS rise.
- IDLE: `miso_oe_out`=0 and SCLK edges are ignored. On nSS fall, latch `status_in` into the TX shifter, clear the bit counter and `byte_count_out`, and drive `status[7]`.
- SCLK rise (synchronized): shift the MOSI sample into the RX shifter and increment the 3-bit bit counter. SCLK fall: shift the next TX bit onto `miso_out`.
- Byte completion (8th rise):
  - CMD: latch the address and direction, then load the TX shifter with `reg[addr]`.
  - DATA write: write the RX byte into `reg[addr]` and pulse `wr_valid_out`.
  - DATA read: no write.
  - Both DATA cases then advance the address and load TX with `reg[new addr]` using write-first bypass. Returned data is therefore the register contents at the time the next byte is clocked, matching MAX3421 "old contents" semantics.
  - `byte_count_out` increments on every completed byte.
- Address advance is +1 mod 32 (31 wraps to 0), subject to Configuration.
- nSS rise mid-byte: partial byte discarded, no write, `txn_done_out` pulses, and `byte_count_out` holds completed bytes until the next nSS fall.
- Reset mid-transaction: all state cleared immediately; the in-flight byte is dropped.
- Reset values: all register file entries 0x00, state IDLE, `miso_out`=0, `miso_oe_out`=0, `wr_valid_out`=0, `wr_addr_out`=0, `wr_data_out`=0, `host_data_out`=0, `txn_done_out`=0, `byte_count_out`=0.
- `host_data_out` sees a DATA write on the cycle after `wr_valid_out`.

## Timing
- Pin-to-event latency: `SYNC_STAGES`+1 cycles (3 at default) for every SCLK/nSS edge.
- MISO changes 1 cycle after a detected SCLK fall.
- The first status bit is valid `SYNC_STAGES`+2 cycles after nSS fall. The host must allow this as nSS-to-SCLK lead; the host engine's one-cycle lead is covered at 8× oversampling.
- Write commit, `wr_valid_out`, and TX reload all occur in the cycle of the 8th-rise event. Next-byte bit 7 is on `miso_out` before the following SCLK fall.
- An SCLK edge and an nSS rise detected in the same cycle: nSS rise wins and the edge is ignored.

## Configuration
- `MAX3421_SPI_RESP_AUTOINC_EN` defined: the address advances after every data byte, as above.
- Undefined: the address is frozen for the whole transaction. All data bytes hit the commanded register, FIFO-style; a write burst returns each previously written byte.

## Structure
- `max3421_pkg` holds:
  - the `state_t` enum (IDLE, CMD, DATA);
  - `REG_COUNT`=32;
  - the command field positions (`CMD_ADDR_MSB`=7, `CMD_ADDR_LSB`=3, `CMD_DIR_BIT`=1).
- Sub-module `spi_input_sync`: a `SYNC_STAGES`-deep synchronizer plus rise/fall edge detect. It is instantiated for SCLK and nSS; MOSI uses the synchronizer only.

## Test plan
- Read: preload reg5=0xA5 via write; `status_in`=0x3C; send 0x28, 0x00 → MISO bytes 0x3C, 0xA5; no `wr_valid_out`; `byte_count_out`=2.
- Write burst (AUTOINC): send 0x52, 0x11, 0x22 → `wr_valid_out` at (10, 0x11) then (11, 0x22); MISO data bytes 0x00, 0x00; `host_data_out` at addr 11 = 0x22.
- Wrap: send 0xFA, 0x01, 0x02 → writes addr 31=0x01, addr 0=0x02.
- Abort: after 0x52, 0x11, raise nSS after 4 bits of the next byte → one write only; `txn_done_out` pulse; `byte_count_out`=2.
- Reset mid-byte with reg10=0x11 → next cycle `miso_oe_out`=0, `host_data_out` for addr 10 reads 0x00, state IDLE.
- AUTOINC undefined: send 0x52, 0x11, 0x22 → both writes to addr 10; MISO third byte 0x11; final reg10=0x22.
